// File: rtl/config_stream_loader_if.sv
// Byte-wide valid/ready configuration stream between a bitstream source and the loader.
interface config_stream_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_stream_loader.sv
// Parses a framed configuration bitstream (TILE, ADDR_HI, ADDR_LO, LEN, data...)
// and drives one registered tile configuration bus write per data byte.
module config_stream_loader #(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
) (
    input  logic                  conf,
    input  logic                  reset,
    config_stream_loader_if.slave in_stream,
    output logic [NUM_TILES-1:0]  select_tile,
    output logic [ADDR_W-1:0]     address_tile,
    output logic [DATA_W-1:0]     data_tile,
    output logic                  config_done,
    output logic                  config_error,
    output logic [15:0]           frame_count
);

    typedef enum logic [2:0] {
        H_TILE,
        H_AHI,
        H_ALO,
        H_LEN,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam int SUM_W = ADDR_W + 9;

    state_t                state;
    logic                  ready;
    logic [7:0]            tile_idx;
    logic [1:0]            addr_hi;
    logic [ADDR_W-1:0]     addr;
    logic [7:0]            remaining;

    logic                  accept;
    logic                  tile_ok;
    logic                  len_overflow;
    logic [SUM_W-1:0]      frame_end;
    logic [NUM_TILES-1:0]  tile_hot;

    assign in_stream.in_ready = ready;
    assign accept             = in_stream.in_valid && ready;
    assign tile_ok            = {1'b0, in_stream.in_data} < 9'(NUM_TILES);

    // One past the last address the frame would touch; beyond the address space means overflow.
    assign frame_end    = SUM_W'(addr) + SUM_W'(in_stream.in_data);
    assign len_overflow = frame_end > SUM_W'(2 ** ADDR_W);

    always_comb begin
        tile_hot = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            tile_hot[i] = (tile_idx == 8'(i));
        end
    end

    always_ff @(posedge conf or negedge reset) begin
        if (!reset) begin
            state        <= H_TILE;
            ready        <= 1'b0;
            tile_idx     <= '0;
            addr_hi      <= '0;
            addr         <= '0;
            remaining    <= '0;
            select_tile  <= '0;
            address_tile <= '0;
            data_tile    <= '0;
            config_done  <= 1'b0;
            config_error <= 1'b0;
            frame_count  <= '0;
        end else begin
            select_tile <= '0;
            ready       <= (state != DONE) && (state != ERROR);

            if (accept) begin
                case (state)
                    H_TILE: begin
                        if (tile_ok) begin
                            tile_idx <= in_stream.in_data;
                            state    <= H_AHI;
                        end else begin
                            state        <= ERROR;
                            ready        <= 1'b0;
                            config_error <= 1'b1;
                        end
                    end
                    H_AHI: begin
                        if (in_stream.in_data[7:2] == 6'd0) begin
                            addr_hi <= in_stream.in_data[1:0];
                            state   <= H_ALO;
                        end else begin
                            state        <= ERROR;
                            ready        <= 1'b0;
                            config_error <= 1'b1;
                        end
                    end
                    H_ALO: begin
                        addr  <= ADDR_W'({addr_hi, in_stream.in_data});
                        state <= H_LEN;
                    end
                    H_LEN: begin
                        if (in_stream.in_data == 8'd0) begin
                            state       <= DONE;
                            ready       <= 1'b0;
                            config_done <= 1'b1;
                        end else if (len_overflow) begin
                            state        <= ERROR;
                            ready        <= 1'b0;
                            config_error <= 1'b1;
                        end else begin
                            remaining <= in_stream.in_data;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        select_tile  <= tile_hot;
                        address_tile <= addr;
                        data_tile    <= DATA_W'(in_stream.in_data);
                        addr         <= addr + ADDR_W'(1);
                        remaining    <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= H_TILE;
                            if (frame_count != 16'hFFFF) begin
                                frame_count <= frame_count + 16'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: streams hand-built frames and checks the tile bus.
module tb_config_stream_loader;

    logic        conf;
    logic        reset;
    logic [15:0] select_tile;
    logic [9:0]  address_tile;
    logic [7:0]  data_tile;
    logic        config_done;
    logic        config_error;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    typedef struct {
        int          cyc;
        logic [15:0] sel;
        logic [9:0]  addr;
        logic [7:0]  data;
    } write_t;

    write_t writes[$];

    config_stream_loader_if stream ();

    config_stream_loader #(.NUM_TILES(16), .ADDR_W(10), .DATA_W(8)) dut (
        .conf         (conf),
        .reset        (reset),
        .in_stream    (stream),
        .select_tile  (select_tile),
        .address_tile (address_tile),
        .data_tile    (data_tile),
        .config_done  (config_done),
        .config_error (config_error),
        .frame_count  (frame_count)
    );

    initial conf = 1'b0;
    always #5 conf = ~conf;

    always @(posedge conf) cycle++;

    // Record every bus strobe as seen mid-cycle.
    always @(negedge conf) begin
        if (select_tile != 16'h0000) begin
            writes.push_back('{cyc: cycle, sel: select_tile, addr: address_tile, data: data_tile});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge conf);
        stream.in_valid = 1'b1;
        stream.in_data  = b;
        @(posedge conf);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge conf);
            stream.in_valid = 1'b0;
        end
    endtask

    task automatic resetDut();
        @(negedge conf);
        stream.in_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge conf);
        reset = 1'b1;
        @(negedge conf);
        writes.delete();
    endtask

    initial begin
        reset           = 1'b0;
        stream.in_valid = 1'b0;
        stream.in_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge conf);
        checkOutput("rst_ready", 32'(stream.in_ready), 32'd0);
        checkOutput("rst_sel", 32'(select_tile), 32'd0);
        checkOutput("rst_addr", 32'(address_tile), 32'd0);
        checkOutput("rst_data", 32'(data_tile), 32'd0);
        checkOutput("rst_done", 32'(config_done), 32'd0);
        checkOutput("rst_err", 32'(config_error), 32'd0);
        checkOutput("rst_fc", 32'(frame_count), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_ready_before_edge", 32'(stream.in_ready), 32'd0);
        @(negedge conf);
        checkOutput("rel_ready_after_edge", 32'(stream.in_ready), 32'd1);
        writes.delete();

        // Back-to-back two-byte frame to tile 3 at 0x005
        applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h05);
        applyStimulus(8'h02); applyStimulus(8'hAA); applyStimulus(8'hBB);
        idleCycles(2);
        checkOutput("bb_count", 32'(writes.size()), 32'd2);
        checkOutput("bb_sel0", 32'(writes[0].sel), 32'h0008);
        checkOutput("bb_addr0", 32'(writes[0].addr), 32'h005);
        checkOutput("bb_data0", 32'(writes[0].data), 32'hAA);
        checkOutput("bb_sel1", 32'(writes[1].sel), 32'h0008);
        checkOutput("bb_addr1", 32'(writes[1].addr), 32'h006);
        checkOutput("bb_data1", 32'(writes[1].data), 32'hBB);
        checkOutput("bb_spacing", 32'(writes[1].cyc - writes[0].cyc), 32'd1);
        checkOutput("bb_sel_idle", 32'(select_tile), 32'd0);
        checkOutput("bb_addr_hold", 32'(address_tile), 32'h006);
        checkOutput("bb_data_hold", 32'(data_tile), 32'hBB);
        checkOutput("bb_fc", 32'(frame_count), 32'd1);
        writes.delete();

        // Same frame with a 3-cycle valid gap between the data bytes
        applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h05);
        applyStimulus(8'h02); applyStimulus(8'hAA);
        idleCycles(3);
        applyStimulus(8'hBB);
        idleCycles(2);
        checkOutput("gap_count", 32'(writes.size()), 32'd2);
        checkOutput("gap_addr0", 32'(writes[0].addr), 32'h005);
        checkOutput("gap_data0", 32'(writes[0].data), 32'hAA);
        checkOutput("gap_addr1", 32'(writes[1].addr), 32'h006);
        checkOutput("gap_data1", 32'(writes[1].data), 32'hBB);
        checkOutput("gap_spacing", 32'(writes[1].cyc - writes[0].cyc), 32'd4);
        checkOutput("gap_fc", 32'(frame_count), 32'd2);

        // Tile index out of range
        resetDut();
        applyStimulus(8'h10);
        idleCycles(1);
        checkOutput("tile_err", 32'(config_error), 32'd1);
        checkOutput("tile_ready", 32'(stream.in_ready), 32'd0);
        checkOutput("tile_done", 32'(config_done), 32'd0);
        applyStimulus(8'h00);
        idleCycles(2);
        checkOutput("tile_nowrite", 32'(writes.size()), 32'd0);
        checkOutput("tile_err_sticky", 32'(config_error), 32'd1);

        // Reserved ADDR_HI bits set
        resetDut();
        applyStimulus(8'h00); applyStimulus(8'h04);
        idleCycles(1);
        checkOutput("ahi_err", 32'(config_error), 32'd1);
        checkOutput("ahi_ready", 32'(stream.in_ready), 32'd0);

        // Length overruns the address space
        resetDut();
        applyStimulus(8'h00); applyStimulus(8'h03); applyStimulus(8'hFF); applyStimulus(8'h02);
        idleCycles(1);
        checkOutput("len_err", 32'(config_error), 32'd1);
        checkOutput("len_ready", 32'(stream.in_ready), 32'd0);
        applyStimulus(8'h77); applyStimulus(8'h88);
        idleCycles(2);
        checkOutput("len_nowrite", 32'(writes.size()), 32'd0);
        checkOutput("len_fc", 32'(frame_count), 32'd0);

        // Frame ending at the top address, then end-of-configuration
        resetDut();
        applyStimulus(8'h01); applyStimulus(8'h03); applyStimulus(8'hFF);
        applyStimulus(8'h01); applyStimulus(8'h5A);
        applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        idleCycles(2);
        checkOutput("top_count", 32'(writes.size()), 32'd1);
        checkOutput("top_sel", 32'(writes[0].sel), 32'h0002);
        checkOutput("top_addr", 32'(writes[0].addr), 32'h3FF);
        checkOutput("top_data", 32'(writes[0].data), 32'h5A);
        checkOutput("top_done", 32'(config_done), 32'd1);
        checkOutput("top_err", 32'(config_error), 32'd0);
        checkOutput("top_ready", 32'(stream.in_ready), 32'd0);
        checkOutput("top_fc", 32'(frame_count), 32'd1);

        // Asynchronous reset in the middle of a 4-byte frame
        resetDut();
        applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h04);
        applyStimulus(8'h11); applyStimulus(8'h22);
        #1;
        stream.in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_sel", 32'(select_tile), 32'd0);
        checkOutput("mid_addr", 32'(address_tile), 32'd0);
        checkOutput("mid_data", 32'(data_tile), 32'd0);
        checkOutput("mid_ready", 32'(stream.in_ready), 32'd0);
        @(negedge conf);
        reset = 1'b1;
        @(negedge conf);
        writes.delete();
        applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h11);
        idleCycles(2);
        checkOutput("post_count", 32'(writes.size()), 32'd1);
        checkOutput("post_sel", 32'(writes[0].sel), 32'h0004);
        checkOutput("post_addr", 32'(writes[0].addr), 32'h000);
        checkOutput("post_data", 32'(writes[0].data), 32'h11);
        checkOutput("post_fc", 32'(frame_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
